mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised load/store unit for the M/W boundary of the pipelined MIPS core. It accepts one memory op at a time from the pipeline and generates byte enables and lane-replicated store data. It drives a ready/valid memory port with variable latency, then extracts and sign/zero-extends load data. It also checks alignment and holds `busy` high so the hazard unit can stall.

Parameters:
- DATA_W, 32, memory bus width; legal values are 32 and 64. BYTES = DATA_W/8 and OFF_W = log2(BYTES).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents an op
- req_ready  out  1  unit accepts the op (only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword only when DATA_W = 64)
- req_unsigned  in  1  zero-extend the load (lbu/lhu/lwu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts the request
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  req_addr with the low OFF_W bits cleared
- mem_be  out  BYTES  byte enables
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  extended load data (0 for stores)
- rsp_err  out  1  address-error flag, valid with rsp_valid
- busy  out  1  asserted whenever state is not IDLE

Behaviour:
- All outputs are registered except req_ready and busy, which decode the state.
- Reset values: state = IDLE, mem_valid = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Reset mid-operation abandons the op. The next cycle is IDLE with all outputs at reset values.
- Offset: off = req_addr[OFF_W-1:0]. nbytes = 1 << req_size.
- Byte enables: mem_be = ((1 << nbytes) - 1) << off.
- Store data: mem_wdata replicates the low nbytes*8 bits of req_wdata across the whole bus.
- Load data:
  - Compute tmp = mem_rdata >> (8*off).
  - Keep the low nbytes*8 bits of tmp.
  - If req_unsigned = 1, zero-extend to DATA_W; otherwise replicate the top kept bit.
  - For a full-width load, pass the data through unchanged.
- Misaligned: (off mod nbytes) != 0, or req_size = 3 when DATA_W = 32.
- State IDLE:
  - req_ready = 1.
  - On req_valid, latch we, size, unsigned, off and the memory fields.
  - If the op is misaligned and checking is enabled, go to RESP with err = 1 and no memory access.
  - Otherwise go to ISSUE with mem_valid = 1.
- State ISSUE:
  - mem_valid and all mem_* outputs stay stable until mem_ready = 1.
  - On handshake, mem_valid drops at the next edge.
  - Store: go to RESP.
  - Load: go to WAIT_R.
- State WAIT_R:
  - On mem_rvalid, register the extracted data into rsp_rdata and go to RESP.
  - mem_rvalid is ignored in every other state.
- State RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE. rsp_err and rsp_rdata hold their values until the next RESP.
- Minimum latency, from acceptance edge to rsp_valid:
  - store with mem_ready already high: 2 cycles
  - load with mem_rvalid in the cycle after the handshake: 3 cycles
  - error response: 1 cycle
- The unit never accepts a new op while busy. There is no back-to-back overlap.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: misaligned ops complete in RESP with rsp_err = 1, and mem_valid is never raised.
- Undefined:
  - rsp_err is tied to 0.
  - off is rounded down to a multiple of nbytes and the access always proceeds.
  - When DATA_W = 32, size 3 is treated as a word access.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD
  - the state enum IDLE, ISSUE, WAIT_R, RESP
- Sub-module load_extract is combinational. Inputs: rdata, off, size, unsigned. Output: the extended data. It is parametrised by DATA_W.

Test Plan (DATA_W = 32):
- lb at addr 0x0000_1003, mem_rdata = 0x80FF_1234 -> rsp_rdata = 0xFFFF_FF80. The same access as lbu -> rsp_rdata = 0x0000_0080.
- lh at addr 0x1002, mem_rdata = 0x8001_7FFF -> rsp_rdata = 0xFFFF_8001. The same access as lhu -> rsp_rdata = 0x0000_8001.
- sb at addr 0x1001, wdata 0x0000_00AB -> mem_addr = 0x1000, mem_be = 4'b0010, mem_wdata = 0xABAB_ABAB.
- sh at addr 0x1002, wdata 0x0000_BEEF -> mem_be = 4'b1100, mem_wdata = 0xBEEF_BEEF.
- mem_ready held low for 3 cycles on a lw -> mem_* outputs stay stable, req_ready = 0, busy = 1. rsp_valid pulses once, the cycle after the cycle in which mem_rvalid = 1.
- lw at addr 0x1002:
  - with ALIGN_CHECK_EN -> rsp_valid = 1 and rsp_err = 1 one cycle after acceptance, and mem_valid is never raised.
  - without ALIGN_CHECK_EN -> mem_addr = 0x1000, mem_be = 4'b1111.
- reset asserted in WAIT_R, then mem_rvalid one cycle later -> the unit is in IDLE with all outputs 0, and rsp_valid is never pulsed.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the M/W load/store unit.
//   size_e  - access size encoding on req_size (byte/half/word/dword)
//   state_e - control state of mem_access_unit
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational load-data alignment and extension.
//   rdata       in  DATA_W  raw bus read data
//   off         in  OFF_W   byte offset of the access within the bus word
//   size        in  2       access size (size_e), already legal for DATA_W
//   is_unsigned in  1       zero-extend instead of sign-extend
//   ext         out DATA_W  right-justified, extended load data
module load_extract
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  size_e             size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] tmp;
  logic [DATA_W-1:0] word_ext;

  always_comb begin
    tmp = rdata >> {off, 3'b000};
  end

  // On a 32-bit bus a word is already full width and passes through.
  if (DATA_W == 32) begin : g_word_full
    always_comb begin
      word_ext = tmp;
    end
  end else begin : g_word_ext
    always_comb begin
      word_ext = {{(DATA_W-32){~is_unsigned & tmp[31]}}, tmp[31:0]};
    end
  end

  always_comb begin
    ext = tmp;
    unique case (size)
      SZ_BYTE: ext = {{(DATA_W-8){~is_unsigned & tmp[7]}}, tmp[7:0]};
      SZ_HALF: ext = {{(DATA_W-16){~is_unsigned & tmp[15]}}, tmp[15:0]};
      SZ_WORD: ext = word_ext;
      default: ext = tmp;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit at the M/W boundary.
// Accepts one op in IDLE, drives a ready/valid memory port with byte
// enables and lane-replicated store data, then returns extended load data
// with a one-cycle rsp_valid pulse. busy holds the pipeline while active.
//   clk, reset             core clock, synchronous active-high reset
//   req_*                  pipeline request (req_ready = unit idle)
//   mem_*                  memory port (registered outputs)
//   rsp_valid/rdata/err    completion pulse, load data, address error
//   busy                   state is not IDLE
// Build option: define ALIGN_CHECK_EN to report misaligned ops via rsp_err
// instead of rounding the offset down and performing the access.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  state_e              state_q;
  logic                we_q;
  size_e               size_q;
  logic                uns_q;
  logic [OFF_W-1:0]    off_q;
  logic                mem_valid_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [BYTES-1:0]    mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  // Request decode, evaluated against the live req_* inputs in IDLE.
  size_e               size_d;
  logic [3:0]          nbytes;
  logic [OFF_W-1:0]    off_mask;
  logic [OFF_W-1:0]    off_raw;
  logic [OFF_W-1:0]    off_d;
  logic                err_d;
  logic [2*BYTES-1:0]  lanes;
  logic [BYTES-1:0]    be_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   ld_data;

  always_comb begin
    size_d = size_e'(req_size);
    // A dword on a 32-bit bus is narrowed to a word so the lane math stays
    // within the bus; with checking enabled it is flagged as an error below.
    if (DATA_W == 32 && req_size == SZ_DWORD) size_d = SZ_WORD;
    nbytes   = 4'd1 << size_d;
    off_mask = OFF_W'(nbytes - 4'd1);
    off_raw  = req_addr[OFF_W-1:0];
`ifdef ALIGN_CHECK_EN
    err_d = (|(off_raw & off_mask)) || (DATA_W == 32 && req_size == SZ_DWORD);
    off_d = off_raw;
`else
    err_d = 1'b0;
    off_d = off_raw & ~off_mask;
`endif
    lanes   = ((2*BYTES)'(1) << nbytes) - (2*BYTES)'(1);
    be_d    = BYTES'(lanes << off_d);
    addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    wdata_d = req_wdata;
    unique case (size_d)
      SZ_BYTE: wdata_d = {BYTES{req_wdata[7:0]}};
      SZ_HALF: wdata_d = {(BYTES/2){req_wdata[15:0]}};
      SZ_WORD: wdata_d = {(BYTES/4){req_wdata[31:0]}};
      default: wdata_d = req_wdata;
    endcase
  end

  load_extract #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_extract (
    .rdata       (mem_rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= size_d;
            uns_q       <= req_unsigned;
            off_q       <= off_d;
            mem_we_q    <= req_we;
            mem_addr_q  <= addr_d;
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            if (err_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end else begin
              mem_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end else begin
              state_q <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= ld_data;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (DATA_W = 32). Expected responses
// are queued when an op is issued and popped when rsp_valid fires.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  mem_access_unit #(
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_ready    = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got mv=%b we=%b addr=%h be=%b wd=%h rv=%b rd=%h err=%b busy=%b, want all 0",
               mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_err, busy);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, req_ready, mem_valid, rsp_valid} !== 4'b0100) begin
      n_bad++;
      $display("FAIL post_reset_idle: got busy/ready/mv/rv=%b want 0100", {busy, req_ready, mem_valid, rsp_valid});
    end
  endtask

  // Issues one op; d = cycle (relative to acceptance) at which mem_ready is
  // raised, so ISSUE sees mem_ready low for max(d-1,0) cycles.
  task automatic run_op(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int d,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    int   t0;
    int   k;
    exp_t e;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: got ready=%b busy=%b want 1/0", name, req_ready, busy);
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    mem_ready    = (d == 0);
    t0           = cyc;
    sb_q.push_back('{exp_rdata, exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    if (!exp_err) begin
      n_cmp++;
      if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, we, exp_addr, exp_be, exp_wdata}) begin
        n_bad++;
        $display("FAIL %s_mem: got mv=%b we=%b addr=%h be=%b wd=%h want 1 %b %h %b %h",
                 name, mem_valid, mem_we, mem_addr, mem_be, mem_wdata, we, exp_addr, exp_be, exp_wdata);
      end
      for (int i = 1; i < d; i++) begin
        @(negedge clk);
        n_cmp++;
        if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata, busy, req_ready, rsp_valid}
            !== {1'b1, we, exp_addr, exp_be, exp_wdata, 1'b1, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL %s_stall%0d: got mv=%b addr=%h be=%b wd=%h busy=%b ready=%b rv=%b",
                   name, i, mem_valid, mem_addr, mem_be, mem_wdata, busy, req_ready, rsp_valid);
        end
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      n_cmp++;
      if (mem_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_mv_drop: got %b want 0", name, mem_valid);
      end
      if (!we) begin
        n_cmp++;
        if ({busy, rsp_valid} !== 2'b10) begin
          n_bad++;
          $display("FAIL %s_wait_r: got busy/rv=%b want 10", name, {busy, rsp_valid});
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end else begin
      n_cmp++;
      if (mem_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_no_access: mem_valid got %b want 0", name, mem_valid);
      end
    end
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: rsp_valid got %b want 1", name, rsp_valid);
    end else begin
      n_cmp++;
      if (cyc - t0 != exp_lat) begin
        n_bad++;
        $display("FAIL %s_latency: got %0d want %0d", name, cyc - t0, exp_lat);
      end
      e = sb_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++;
        $display("FAIL %s_rsp: got rdata=%h err=%b want rdata=%h err=%b", name, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++;
        $display("FAIL %s_after: got rv=%b busy=%b rdata=%h err=%b want 0 0 %h %b",
                 name, rsp_valid, busy, rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_loads();
    run_op("lb",  1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
           32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    run_op("lbu", 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
           32'h1000, 4'b1000, 32'h0, 32'h0000_0080, 1'b0, 3);
    run_op("lh",  1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 1,
           32'h1000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 3);
    run_op("lhu", 1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 0,
           32'h1000, 4'b1100, 32'h0, 32'h0000_8001, 1'b0, 3);
    run_op("lb_pos", 1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 32'h0000_7F00, 0,
           32'h2000, 4'b0010, 32'h0, 32'h0000_007F, 1'b0, 3);
  endtask

  task automatic test_stores();
    run_op("sb", 1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h0000_00AB, 32'h0, 0,
           32'h1000, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0, 2);
    run_op("sh", 1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h0000_BEEF, 32'h0, 1,
           32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 2);
    run_op("sw", 1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0,
           32'h1004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
  endtask

  task automatic test_stall();
    run_op("lw_stall", 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 32'h1234_5678, 4,
           32'h1000, 4'b1111, 32'h0, 32'h1234_5678, 1'b0, 6);
    run_op("sw_stall", 1'b1, 2'd2, 1'b0, 32'h0000_3008, 32'h0BAD_F00D, 32'h0, 3,
           32'h3008, 4'b1111, 32'h0BAD_F00D, 32'h0, 1'b0, 4);
  endtask

  task automatic test_misaligned();
`ifdef ALIGN_CHECK_EN
    run_op("lw_mis", 1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 0,
           32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1);
    run_op("lh_mis", 1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 32'h1234_ABCD, 0,
           32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1);
    run_op("sd_32", 1'b1, 2'd3, 1'b0, 32'h0000_1000, 32'h5555_AAAA, 32'h0, 0,
           32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1);
`else
    run_op("lw_mis", 1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 0,
           32'h1000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    run_op("lh_mis", 1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 32'h1234_ABCD, 0,
           32'h1000, 4'b0011, 32'h0, 32'hFFFF_ABCD, 1'b0, 3);
    run_op("ld_32", 1'b0, 2'd3, 1'b0, 32'h0000_1004, 32'h0, 32'h89AB_CDEF, 0,
           32'h1004, 4'b1111, 32'h0, 32'h89AB_CDEF, 1'b0, 3);
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h0000_4000;
    req_wdata    = 32'h0;
    mem_ready    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    n_cmp++;
    if ({busy, mem_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rstmid_wait_r: got busy/mv=%b want 10", {busy, mem_valid});
    end
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    n_cmp++;
    if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_err, busy} !== '0
        || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got mv=%b addr=%h be=%b rv=%b rd=%h err=%b busy=%b ready=%b want all 0, ready 1",
               mem_valid, mem_addr, mem_be, rsp_valid, rsp_rdata, rsp_err, busy, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL rstmid_quiet%0d: got rv=%b busy=%b rd=%h want 0 0 0", i, rsp_valid, busy, rsp_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_stall();
    test_misaligned();
    test_reset_mid();
    run_op("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h0F0F_0F0F, 0,
           32'h5000, 4'b1111, 32'h0, 32'h0F0F_0F0F, 1'b0, 3);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
